// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: NUM_REQ requesters share one flush-to-zero FP multiplier (Mul).
// Operands are registered in front of Mul and the product behind it, so an op
// takes two edges, the block accepts one op per cycle and results stay in order.
// Config macro FP_MUL_ARB_FIXED_PRIO_EN: lowest asserted index always wins
// (round-robin pointer removed). Default build is round-robin.

// Mul: sign | 8-bit exponent (bias 127) | MANTISSA fraction. Denormal inputs and
// underflowing results are flushed to +0, products are truncated, NaN is canonical.
module Mul #(
    parameter int MANTISSA = 8,
    localparam int WIDTH   = MANTISSA + 9
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o
);
    localparam int PW = 2 * MANTISSA + 2;

    logic                sa, sb;
    logic [7:0]          ea, eb;
    logic [MANTISSA-1:0] fa, fb;
    logic [PW-1:0]       prod;
    logic                norm;
    logic signed [10:0]  exp_s;
    logic [MANTISSA-1:0] frac;
    logic                zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                unused_lsbs;

    assign {sa, ea, fa} = a_i;
    assign {sb, eb, fb} = b_i;
    assign prod   = {1'b1, fa} * {1'b1, fb};
    // Significand product lies in [1,4); the top bit says whether to renormalise.
    assign norm   = prod[PW-1];
    assign frac   = norm ? prod[PW-2 -: MANTISSA] : prod[PW-3 -: MANTISSA];
    assign exp_s  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
                  + $signed({10'd0, norm});
    assign unused_lsbs = ^prod[MANTISSA-1:0];

    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == '0);
    assign inf_b  = (eb == 8'hFF) && (fb == '0);
    assign nan_a  = (ea == 8'hFF) && (fa != '0);
    assign nan_b  = (eb == 8'hFF) && (fb != '0);

    // Special operands first, then overflow to Inf / underflow to +0.
    always_comb begin
        p_o = '0;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            p_o = {1'b0, 8'hFF, 1'b1, {(MANTISSA-1){1'b0}}};
        else if (inf_a || inf_b)
            p_o = {sa ^ sb, 8'hFF, {MANTISSA{1'b0}}};
        else if (zero_a || zero_b)
            p_o = '0;
        else if (exp_s >= 11'sd255)
            p_o = {sa ^ sb, 8'hFF, {MANTISSA{1'b0}}};
        else if (exp_s <= 11'sd0)
            p_o = '0;
        else
            p_o = {sa ^ sb, exp_s[7:0], frac};
    end
endmodule

module fp_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MANTISSA = 8,
    localparam int WIDTH   = MANTISSA + 9,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [ID_W-1:0]          resp_id_o,
    output logic [WIDTH-1:0]         resp_data_o,
    output logic                     busy_o
);
    logic [NUM_REQ-1:0] grant, search;
    logic [ID_W-1:0]    grant_idx, base, off;
    logic [ID_W:0]      idx_sum;
    logic               found, accept;
    logic               s2_en, s1_adv, accept_ok;
    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic [WIDTH-1:0]   mul_p;

    logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_data_q, s2_data_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d, s2_id_q, s2_id_d;

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    assign base   = '0;
    assign search = req_valid_i;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    // Rotate so that bit 0 of search is the requester at rr_ptr.
    assign base   = rr_ptr_q;
    assign search = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a_i[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b_i[g*WIDTH +: WIDTH];
    end

    // Lowest set bit of the rotated request vector, mapped back to a requester index.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (search[k]) begin
                found = 1'b1;
                off   = ID_W'(k);
            end
        end
        idx_sum = {1'b0, base} + {1'b0, off};
        if (idx_sum >= (ID_W+1)'(NUM_REQ))
            idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
        grant_idx = idx_sum[ID_W-1:0];
        grant     = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign s2_en       = !s2_valid_q || resp_ready_i;
    assign s1_adv      = s1_valid_q && s2_en;
    assign accept_ok   = !s1_valid_q || s1_adv;
    assign req_ready_o = grant & {NUM_REQ{accept_ok}};
    assign accept      = found && accept_ok;

    Mul #(.MANTISSA(MANTISSA)) u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (mul_p)
    );

    // Next state: s1 loads on accept (refill with no bubble), s2 loads when free or drained.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a_arr[grant_idx];
            s1_b_d     = b_arr[grant_idx];
            s1_id_d    = grant_idx;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = mul_p;
            s2_id_d    = s1_id_q;
        end
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (accept)
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign resp_valid_o = s2_valid_q;
    assign resp_data_o  = s2_data_q;
    assign resp_id_o    = s2_id_q;
    assign busy_o       = s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter (NUM_REQ=4, MANTISSA=8). A queue-based model predicts
// grants, response timing and products (real-valued arithmetic); directed vectors
// add literal expectations. Honors FP_MUL_ARB_FIXED_PRIO_EN.
module tb_fp_mul_arbiter;
    localparam int N   = 4;
    localparam int M   = 8;
    localparam int W   = M + 9;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic           resp_valid, busy;
    logic           resp_ready = 1'b1;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_data;

    int nvec = 0, nfail = 0;
    int n_acc = 0, n_ret = 0, cnt = 0;
    bit refill = 0, rand_mode = 0;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NUM_REQ(N), .MANTISSA(M)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .busy_o       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product from real arithmetic (exact for 8-bit fractions).
    function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ea, eb, fa, fb, e, frac;
        real r;
        bit s;
        ea = int'(a[15:8]); eb = int'(b[15:8]);
        fa = int'(a[7:0]);  fb = int'(b[7:0]);
        s  = a[16] ^ b[16];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
            return 17'h0FF80;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 8'h00};
        if (ea == 0 || eb == 0) return '0;
        r = (1.0 + real'(fa) / 256.0) * (1.0 + real'(fb) / 256.0);
        e = ea + eb - 254;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        e += 127;
        if (e >= 255) return {s, 8'hFF, 8'h00};
        if (e <= 0) return '0;
        frac = $rtoi((r - 1.0) * 256.0);
        return {s, 8'(e), 8'(frac)};
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v, input int p);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    typedef struct { int id; logic [W-1:0] data; int age; } op_t;
    op_t q[$];
    int  ptr = 0;
    bit  model_ok = 0;
    logic [N-1:0] acc_s = '0;
    int  exp_acc = -1;
    bit  exp_pop = 0, rst_s = 0;
    logic [W-1:0] exp_a, exp_b;

    // Compare DUT against the model mid-cycle and note what the next edge should do.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        bit ok, ev;
        acc_s = req_valid & req_ready;
        rst_s = reset;
        exp_acc = -1;
        exp_pop = 0;
        if (model_ok) begin
            ok = (q.size() < 2) || resp_ready;
            g  = exp_grant(req_valid, ptr);
            er = (ok && g >= 0) ? (N'(1) << g) : '0;
            ev = (q.size() > 0) && (q[0].age >= 2);
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            if (ev) begin
                chk("resp_id", 32'(resp_id), 32'(q[0].id));
                chk("resp_data", 32'(resp_data), 32'(q[0].data));
            end
            if (ok && g >= 0) begin
                exp_acc = g;
                exp_a   = req_a[g*W +: W];
                exp_b   = req_b[g*W +: W];
            end
            exp_pop = ev && resp_ready;
        end
    end

    // Model state advance on each edge.
    always @(posedge clk) begin
        if (rst_s) begin
            q.delete();
            ptr = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (exp_pop) begin
                void'(q.pop_front());
                n_ret++;
            end
            foreach (q[i]) q[i].age++;
            if (exp_acc >= 0) begin
                q.push_back('{id: exp_acc, data: mul_model(exp_a, exp_b), age: 1});
                ptr = (exp_acc + 1) % N;
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_s;
        for (int i = 0; i < N; i++) begin
            if (refill && !req_valid[i] && (!rand_mode || $urandom_range(0, 2) == 0)) begin
                cnt++;
                if (rand_mode) begin
                    req_a[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                    : {1'($urandom), 8'($urandom_range(60, 190)), 8'($urandom)};
                    req_b[i*W +: W] = {1'($urandom), 8'($urandom_range(60, 190)), 8'($urandom)};
                end else begin
                    req_a[i*W +: W] = {1'b0, 8'(120 + i), 8'(cnt * 37)};
                    req_b[i*W +: W] = {1'b0, 8'd128, 8'(cnt)};
                end
                req_valid[i] = 1'b1;
            end
        end
        if (rand_mode) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (req_valid != '0 || busy); i++) tick();
        chk("drain", {30'd0, req_valid != '0, busy}, 32'd0);
    endtask

    // One isolated op on an idle block: immediate grant, response two edges later.
    task automatic issue(input string name, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        chk({name, "_ready"}, 32'(req_ready), 32'(N'(1) << idx));
        tick();
        tick();
        @(negedge clk);
        chk({name, "_valid"}, 32'(resp_valid), 32'd1);
        chk({name, "_data"}, 32'(resp_data), 32'(exp_d));
        chk({name, "_id"}, 32'(resp_id), 32'(idx));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Model anchors
        chk("model_3p0", 32'(mul_model(17'h07F80, 17'h08000)), 32'h08080);
        chk("model_ftz", 32'(mul_model(17'h00000, 17'h17F00)), 32'h00000);
        chk("model_inf", 32'(mul_model(17'h0FF00, 17'h07F00)), 32'h0FF00);

        // Reset state
        repeat (3) tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        reset = 1'b0;

        // Single op and FTZ / Inf passthrough
        issue("single", 2, 17'h07F80, 17'h08000, 17'h08080);
        issue("ftz", 1, 17'h00000, 17'h17F00, 17'h00000);
        issue("inf", 1, 17'h0FF00, 17'h07F00, 17'h0FF00);

        // Round-robin under full load
        do_reset();
        refill = 1;
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
            chk("grant_order", 32'(req_ready), 32'd1);
`else
            chk("grant_order", 32'(req_ready), 32'd1 << (k % N));
`endif
            tick();
        end
        refill = 0;
        drain();

        // Backpressure with three queued requests
        do_reset();
        resp_ready = 1'b0;
        req_a[0*W +: W] = 17'h07F80; req_b[0*W +: W] = 17'h08000;   // 3.0
        req_a[1*W +: W] = 17'h07F00; req_b[1*W +: W] = 17'h07F00;   // 1.0
        req_a[2*W +: W] = 17'h08000; req_b[2*W +: W] = 17'h08000;   // 4.0
        req_valid = 4'b0111;
        @(negedge clk); chk("bp_acc1", 32'(req_ready), 32'b0001);
        tick();
        @(negedge clk); chk("bp_acc2", 32'(req_ready), 32'b0010);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_data", 32'(resp_data), 32'h08080);
            chk("bp_hold_id", 32'(resp_id), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk); chk("bp_acc3", 32'(req_ready), 32'b0100);
        tick();
        @(negedge clk); chk("bp_drain1", 32'(resp_data), 32'h07F00);
        chk("bp_drain1_id", 32'(resp_id), 32'd1);
        tick();
        @(negedge clk); chk("bp_drain2", 32'(resp_data), 32'h08100);
        chk("bp_drain2_id", 32'(resp_id), 32'd2);
        drain();

        // Reset with both stages full
        resp_ready = 1'b0;
        req_a[1*W +: W] = 17'h07F80; req_b[1*W +: W] = 17'h07F80;
        req_a[3*W +: W] = 17'h08000; req_b[3*W +: W] = 17'h07F80;
        req_valid = 4'b1010;
        tick();
        tick();
        chk("mid_full_busy", 32'(busy), 32'd1);
        chk("mid_full_valid", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        req_valid = '0;
        tick();
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        resp_ready = 1'b1;
        tick();
        tick();
        @(negedge clk); chk("no_stale", 32'(resp_valid), 32'd0);
        refill = 1;
        tick();
        @(negedge clk); chk("post_rst_grant", 32'(req_ready), 32'b0001);
        refill = 0;
        drain();

        // Random valid/ready traffic against the model
        n_acc = 0;
        n_ret = 0;
        rand_mode = 1;
        refill = 1;
        repeat (400) tick();
        rand_mode = 0;
        refill = 0;
        resp_ready = 1'b1;
        drain();
        chk("rand_all_returned", 32'(n_ret), 32'(n_acc));
        chk("rand_queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
